adder_arbiter: RTL
==================

# adder_arbiter

Round-robin arbiter and sequencer that shares one combinational WIDTH-bit ripple-carry adder between N_REQ requesters. Accepts one operand set at a time over a valid/ready handshake and drives the shared adder from registered operands. Waits SETTLE_CYCLES for the carry chain to settle, then returns the registered sum and carry-out tagged with the requester id. Sits between requester blocks and the single shared adder instance; the adder itself is external.

## Interface
- N_REQ, 4: number of requesters, 2..16.
- WIDTH, 32: operand width.
- SETTLE_CYCLES, 2: cycles the adder inputs are held stable before the result is sampled, ≥1.
- ID_W, $clog2(N_REQ): derived local parameter.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request.
- req_ready  out  N_REQ  one-hot grant/accept, or all zero.
- req_a  in  N_REQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  operand B, same packing.
- req_cin  in  N_REQ  carry-in per requester.
- add_a, add_b  out  WIDTH  operands driven to the shared adder.
- add_cin  out  1  carry-in to the shared adder.
- add_sum  in  WIDTH  adder sum.
- add_cout  in  1  adder carry-out.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  ID_W  index of the requester that owns the result.
- resp_sum  out  WIDTH  registered sum.
- resp_cout  out  1  registered carry-out.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SETTLE, RESP.
- **IDLE**
  - If any req_valid is high, the round-robin winner gets req_ready[w]=1 combinationally; all other req_ready bits are 0.
  - On the accepting edge: op register ← {req_a[w], req_b[w], req_cin[w]}; id register ← w; last-grant pointer ← w; settle counter ← SETTLE_CYCLES−1; state → SETTLE.
- **Priority**: search starts at (last+1) mod N_REQ. After reset last = N_REQ−1, so requester 0 has top priority.
- **SETTLE**
  - add_a, add_b and add_cin come from the op register only, and are stable for the whole hold.
  - The counter decrements each cycle. The edge where the counter is 0 captures resp_sum ← add_sum and resp_cout ← add_cout, and moves state to RESP.
- **RESP**
  - resp_valid=1. resp_id, resp_sum and resp_cout are held until resp_valid && resp_ready.
  - On that edge, state → IDLE.
- **Arithmetic**: no width change; the sum is modulo 2^WIDTH and the carry goes out on resp_cout. The block never computes the sum itself.
- **Requester side**: a requester must hold req_valid and its operands until it sees req_ready. The block never accepts while busy.
- **Withdrawn request**: a requester that drops req_valid before being granted loses nothing; no state is changed.
- add_a, add_b and add_cin keep the last op register value in IDLE and RESP, so the adder does not toggle spuriously.

## Timing
- **Reset values** on the rst edge:
  - state=IDLE, last=N_REQ−1, op register=0.
  - resp_sum=0, resp_cout=0, resp_id=0.
  - resp_valid=0, busy=0.
  - req_ready=0 while rst is high.
- **Latency**: accepted in cycle c0, SETTLE in cycles c0+1..c0+SETTLE_CYCLES, resp_valid high from cycle c0+SETTLE_CYCLES+1.
- **Throughput**: with resp_ready held high, the next accept is possible at c0+SETTLE_CYCLES+2. That gives one operation per SETTLE_CYCLES+2 cycles.
- **Simultaneous requests**: exactly one grant per IDLE cycle; the others wait. No requester waits more than N_REQ−1 grants.
- **Response backpressure**: resp_ready low in RESP holds all resp_* outputs unchanged indefinitely. req_ready stays all zero meanwhile.
- **Reset mid-operation**: an in-flight op is dropped with no response, and all outputs return to their reset values on the next edge.
- **SETTLE_CYCLES=1**: a single SETTLE cycle; the counter loads 0.

## Structure
- **Package adder_ctrl_pkg**:
  - state enum {IDLE, SETTLE, RESP};
  - default WIDTH and N_REQ constants;
  - a function that returns the operand slice for index i.
- **Sub-module rr_arbiter**:
  - parameter N;
  - inputs req[N] and last[ID_W], plus en (high only in IDLE);
  - outputs one-hot gnt[N], gnt_idx and any_req.
  - Purely combinational; the last-grant pointer register lives in adder_arbiter.

## Test plan
- **Single request, SETTLE_CYCLES=2**: req 1 presents a=0xFFFF_FFFF, b=0x0000_0001, cin=0 → req_ready[1] at c0; resp_valid at c0+3 with sum=0x0000_0000, cout=1, id=1.
- **Fairness, all four requesting continuously**: four requesters each send unique operands → grant order 0,1,2,3,0; every response id matches its operands; sum=a+b+cin checked.
- **Response backpressure**: resp_ready held low for 10 cycles with req 2 waiting → resp_* stable; req_ready=0 throughout; req 2 granted the cycle after resp_ready rises.
- **Operand hold**: a requester changes req_a after acceptance → add_a stays at the accepted value through SETTLE; the result uses the accepted operands.
- **Reset mid-SETTLE**: rst asserted in the first SETTLE cycle → resp_valid never rises; state IDLE; next request granted to requester 0 first.
- **Random**: 2,000 random operations with random resp_ready, checked against a reference model → zero mismatches and no lost or duplicated responses.

Source files
------------

// File: rtl/adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_ctrl_pkg
// Brief    : Shared types and helpers for the shared-adder arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package adder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int C_DEF_WIDTH = 32;
  localparam int C_DEF_N_REQ = 4;

  // LSB position of requester idx's operand slice in a packed operand bus
  function automatic int op_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick starting after the last grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_last,
  input  logic            i_en,
  output logic [N-1:0]    o_gnt,
  output logic [ID_W-1:0] o_gnt_idx,
  output logic            o_any_req
);

  logic w_found;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      logic [ID_W-1:0] w_pos;
      w_pos = ID_W'((int'(i_last) + k) % N);
      if (i_en && !w_found && i_req[w_pos]) begin
        w_found      = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_gnt_idx    = w_pos;
      end
    end
    o_any_req = w_found;
  end

endmodule
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_arbiter
// Brief    : Round-robin sequencer sharing one external adder among N_REQ users.
// Revision : 1.0 - initial release
// ============================================================================
module adder_arbiter
  import adder_ctrl_pkg::*;
#(
  parameter  int N_REQ         = C_DEF_N_REQ,
  parameter  int WIDTH         = C_DEF_WIDTH,
  parameter  int SETTLE_CYCLES = 2,
  localparam int ID_W          = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_cin,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  output logic                   add_cin,
  input  logic [WIDTH-1:0]       add_sum,
  input  logic                   add_cout,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [WIDTH-1:0]       resp_sum,
  output logic                   resp_cout,
  output logic                   busy
);

  localparam int C_CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t              r_state, w_next;
  logic [ID_W-1:0]     r_last, r_id;
  logic [WIDTH-1:0]    r_op_a, r_op_b, r_sum;
  logic                r_op_cin, r_cout;
  logic [C_CNT_W-1:0]  r_cnt;

  logic [N_REQ-1:0]    w_gnt;
  logic [ID_W-1:0]     w_gnt_idx;
  logic                w_any;
  logic [WIDTH-1:0]    w_sel_a, w_sel_b;
  logic                w_sel_cin;

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .i_req     (req_valid),
    .i_last    (r_last),
    .i_en      ((r_state == IDLE) && !rst),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any_req (w_any)
  );

  always_comb begin
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_cin = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_idx == ID_W'(i)) begin
        w_sel_a   = req_a[op_lsb(i, WIDTH) +: WIDTH];
        w_sel_b   = req_b[op_lsb(i, WIDTH) +: WIDTH];
        w_sel_cin = req_cin[i];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = SETTLE;
      SETTLE:  if (r_cnt == '0) w_next = RESP;
      RESP:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= ID_W'(N_REQ - 1);
      r_id     <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_op_cin <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_op_a   <= w_sel_a;
            r_op_b   <= w_sel_b;
            r_op_cin <= w_sel_cin;
            r_id     <= w_gnt_idx;
            r_last   <= w_gnt_idx;
            r_cnt    <= C_CNT_W'(SETTLE_CYCLES - 1);
          end
        end
        SETTLE: begin
          if (r_cnt == '0) begin
            r_sum  <= add_sum;
            r_cout <= add_cout;
          end else begin
            r_cnt <= r_cnt - C_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Adder inputs come only from the op register so they never toggle outside an accept
  assign add_a      = r_op_a;
  assign add_b      = r_op_b;
  assign add_cin    = r_op_cin;
  assign req_ready  = w_gnt;
  assign resp_valid = (r_state == RESP);
  assign busy       = (r_state != IDLE);
  assign resp_id    = r_id;
  assign resp_sum   = r_sum;
  assign resp_cout  = r_cout;

endmodule
`default_nettype wire
